// File: rtl/uart_result_sender_if.sv
// Handshake and line signals between a CNN result producer and the UART result sender.
// The producer side uses the master modport. The sender side uses the slave modport.
interface uart_result_sender_if #(
    parameter int RESULT_W = 80
);
    logic                start_i;
    logic [RESULT_W-1:0] result_i;
    logic                tx_o;
    logic                busy_o;
    logic                tx_done_tick_o;

    modport master (
        output start_i,
        output result_i,
        input  tx_o,
        input  busy_o,
        input  tx_done_tick_o
    );

    modport slave (
        input  start_i,
        input  result_i,
        output tx_o,
        output busy_o,
        output tx_done_tick_o
    );
endinterface

// File: rtl/uart_result_sender.sv
// Latches a finished CNN result vector and sends it to the host as back-to-back 8N1 UART frames.
// An optional header byte is sent first. The payload follows in byte order, least significant byte first.
module uart_result_sender #(
    parameter int         CLK_FREQ    = 100_000_000,
    parameter int         BAUD_RATE   = 115_200,
    parameter int         RESULT_W    = 80,
    parameter int         HEADER_EN   = 1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_result_sender_if.slave  bus
);
    localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int NBYTES    = RESULT_W / 8;
    localparam int NFRAMES   = NBYTES + ((HEADER_EN != 0) ? 1 : 0);
    localparam int BAUD_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int IDX_W     = (NBYTES > 0) ? $clog2(NBYTES + 1) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NFRAMES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [RESULT_W-1:0] buf_q, buf_d;
    logic [7:0]          cur_byte_q, cur_byte_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;
    logic                more_bytes;

    assign bit_end    = (baud_cnt_q == BAUD_LAST);
    assign more_bytes = (byte_idx_q != IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start_i) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:  if (bit_end) state_d = more_bytes ? START : DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Baud timing, bit/byte indices and the payload shift buffer.
    always_comb begin
        baud_cnt_d = '0;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        cur_byte_d = cur_byte_q;
        if ((state_q == START) || (state_q == DATA) || (state_q == STOP)) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end
        if (state_q == START) begin
            bit_idx_d = 3'd0;
        end
        if ((state_q == DATA) && bit_end) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end
        if ((state_q == IDLE) && bus.start_i) begin
            byte_idx_d = '0;
            if (HEADER_EN != 0) begin
                buf_d      = bus.result_i;
                cur_byte_d = HEADER_BYTE;
            end else begin
                buf_d      = bus.result_i >> 8;
                cur_byte_d = bus.result_i[7:0];
            end
        end
        if ((state_q == STOP) && bit_end && more_bytes) begin
            byte_idx_d = byte_idx_q + 1'b1;
            cur_byte_d = buf_q[7:0];
            buf_d      = buf_q >> 8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q      <= buf_d;
        cur_byte_q <= cur_byte_d;
    end

    // Outputs are decoded from the next state so that the registered outputs line up with state_q.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = cur_byte_d[bit_idx_d];
                busy_d = 1'b1;
            end
            STOP: busy_d = 1'b1;
            DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.tx_o           = tx_q;
    assign bus.busy_o         = busy_q;
    assign bus.tx_done_tick_o = done_q;
endmodule

// File: tb/tb_uart_result_sender.sv
// Directed bench for uart_result_sender: a 16-bit instance with a header and an 80-bit instance without one.
// Expected bytes are queued at start and popped as each frame is decoded from the line.
module tb_uart_result_sender;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic line, busy_m, done_m;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_result_sender_if #(.RESULT_W(16)) ifa ();
    uart_result_sender_if #(.RESULT_W(80)) ifb ();

    uart_result_sender #(
        .CLK_FREQ(16), .BAUD_RATE(1), .RESULT_W(16), .HEADER_EN(1), .HEADER_BYTE(8'hA5)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    uart_result_sender #(
        .CLK_FREQ(16), .BAUD_RATE(1), .RESULT_W(80), .HEADER_EN(0), .HEADER_BYTE(8'hA5)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always_comb begin
        line   = sel ? ifb.tx_o           : ifa.tx_o;
        busy_m = sel ? ifb.busy_o         : ifa.busy_o;
        done_m = sel ? ifb.tx_done_tick_o : ifa.tx_done_tick_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start_a(input logic [15:0] r);
        @(negedge clk);
        ifa.result_i = r;
        ifa.start_i  = 1'b1;
        sb.push_back(8'hA5);
        sb.push_back(r[7:0]);
        sb.push_back(r[15:8]);
        @(negedge clk);
        ifa.start_i = 1'b0;
        chk("lat_tx_a", line, 1'b0);
        chk("lat_busy_a", busy_m, 1'b1);
    endtask

    // Samples every cycle of each frame: bit values, per-bit duration, busy high and no early tick.
    task automatic recv(input int nframes, input int inject_at);
        logic [7:0] exp_b, dec;
        logic [9:0] pat;
        int bad;
        int g;
        g = 0;
        for (int f = 0; f < nframes; f++) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
                exp_b = 8'h00;
            end else begin
                exp_b = sb.pop_front();
            end
            pat = {1'b1, exp_b, 1'b0};
            bad = 0;
            dec = 8'h00;
            for (int s = 0; s < 160; s++) begin
                if ((line !== pat[s / 16]) || (busy_m !== 1'b1) || (done_m !== 1'b0)) bad++;
                if ((s % 16 == 8) && (s >= 16) && (s < 144)) dec[s / 16 - 1] = line;
                if (inject_at >= 0 && g == inject_at) begin
                    ifa.result_i = 16'hFFFF;
                    ifa.start_i  = 1'b1;
                end else if (inject_at >= 0 && g == inject_at + 1) begin
                    ifa.start_i = 1'b0;
                end
                g++;
                @(negedge clk);
            end
            chk($sformatf("frame%0d_timing", f), bad, 0);
            chk($sformatf("frame%0d_byte", f), dec, exp_b);
        end
        chk("done_tick", done_m, 1'b1);
        chk("done_busy", busy_m, 1'b0);
        chk("done_tx", line, 1'b1);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int bad;
        logic [79:0] rb;
        ifa.start_i  = 1'b0;
        ifa.result_i = '0;
        ifb.start_i  = 1'b0;
        ifb.result_i = '0;

        // Reset and idle line
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", ifa.tx_o, 1'b1);
        chk("rst_busy", ifa.busy_o, 1'b0);
        chk("rst_done", ifa.tx_done_tick_o, 1'b0);
        chk("rst_tx_b", ifb.tx_o, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.tx_o !== 1'b1 || ifa.busy_o !== 1'b0 || ifa.tx_done_tick_o !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);

        // Header plus two payload bytes
        sel = 1'b0;
        do_start_a(16'h3C81);
        recv(3, -1);

        // Ten payload bytes with no header
        sel = 1'b1;
        rb  = 80'h09_08_07_06_05_04_03_02_01_00;
        @(negedge clk);
        ifb.result_i = rb;
        ifb.start_i  = 1'b1;
        for (int i = 0; i < 10; i++) sb.push_back(8'(i));
        @(negedge clk);
        ifb.start_i = 1'b0;
        chk("lat_tx_b", line, 1'b0);
        chk("lat_busy_b", busy_m, 1'b1);
        recv(10, -1);

        // Start and new data while busy are ignored
        sel = 1'b0;
        do_start_a(16'h5AC3);
        recv(3, 200);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_m !== 1'b0 || line !== 1'b1 || busy_m !== 1'b0) bad++;
        end
        chk("no_extra_frame", bad, 0);

        // Reset in the middle of a data bit
        do_start_a(16'h1234);
        repeat (40) @(negedge clk);
        chk("pre_rst_tx", line, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", line, 1'b1);
        chk("abort_busy", busy_m, 1'b0);
        chk("abort_done", done_m, 1'b0);
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_m !== 1'b0 || line !== 1'b1) bad++;
        end
        rst = 1'b0;
        sb.delete();
        repeat (5) begin
            @(negedge clk);
            if (done_m !== 1'b0 || line !== 1'b1 || busy_m !== 1'b0) bad++;
        end
        chk("abort_quiet", bad, 0);
        do_start_a(16'hBEEF);
        recv(3, -1);

        // Start in the done cycle is ignored, start one cycle later is accepted
        ifa.result_i = 16'h7E11;
        ifa.start_i  = 1'b1;
        @(negedge clk);
        chk("done_start_tx", line, 1'b1);
        chk("done_start_busy", busy_m, 1'b0);
        sb.push_back(8'hA5);
        sb.push_back(8'h11);
        sb.push_back(8'h7E);
        @(negedge clk);
        ifa.start_i = 1'b0;
        chk("next_start_tx", line, 1'b0);
        chk("next_start_busy", busy_m, 1'b1);
        recv(3, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
